// File: rtl/lcd_sequencer_if.sv
// Bus bundle between the LCD sequencer, its content ROM, the LCD panel and
// the controlling logic that issues start and watches busy/done.
interface lcd_sequencer_if;
  logic       start;
  logic [3:0] rom_addr;
  logic [8:0] rom_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       done;

  // The sequencer side: drives the ROM address, the LCD pins and status.
  modport master (
    input  start,
    input  rom_data,
    output rom_addr,
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_db,
    output busy,
    output done
  );

  // The environment side: ROM, panel and controller.
  modport slave (
    output start,
    output rom_data,
    input  rom_addr,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_db,
    input  busy,
    input  done
  );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 8-bit parallel-bus sequencer: waits for panel power-up, issues a
// fixed four-command init sequence, then writes all 16 words of the content
// ROM with SETUP / E-pulse / post-write wait timing. A start pulse in DONE
// replays the ROM stream without re-running init.
module lcd_sequencer #(
  parameter int unsigned POWERUP_CYC  = 2000000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned E_PULSE_CYC  = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  lcd_sequencer_if.master bus
);

  // One shared down-the-phases counter, wide enough for the longest interval.
  localparam int unsigned MAX_AB  = (POWERUP_CYC  > SETUP_CYC)    ? POWERUP_CYC  : SETUP_CYC;
  localparam int unsigned MAX_CD  = (E_PULSE_CYC  > CMD_WAIT_CYC) ? E_PULSE_CYC  : CMD_WAIT_CYC;
  localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_CYC = (MAX_ABC > CLR_WAIT_CYC) ? MAX_ABC : CLR_WAIT_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST     = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_FETCH,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic {
    PH_INIT,
    PH_ROM
  } phase_e;

  // Fixed init commands: function set 8-bit/2-line, display+cursor on,
  // clear, entry-mode increment.
  function automatic logic [7:0] init_cmd(input logic [1:0] sel);
    logic [7:0] cmd;
    case (sel)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0E;
      2'd2:    cmd = 8'h01;
      default: cmd = 8'h06;
    endcase
    return cmd;
  endfunction

  state_e           state_q,    state_d;
  phase_e           phase_q,    phase_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [3:0]       idx_q,      idx_d;
  logic [3:0]       rom_addr_q, rom_addr_d;
  logic             rs_q,       rs_d;
  logic [7:0]       db_q,       db_d;
  logic             e_q,        e_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic             is_clr;
  logic [CNT_W-1:0] wait_last;
  logic [8:0]       word;

  // Clear and return-home need the long post-write wait.
  assign is_clr    = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02));
  assign wait_last = is_clr ? CLR_LAST : CMD_LAST;
  assign word      = (phase_q == PH_INIT) ? {1'b0, init_cmd(idx_q[1:0])} : bus.rom_data;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_POWERUP;
      phase_q    <= PH_INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      rs_q       <= 1'b0;
      db_q       <= '0;
      e_q        <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      rs_q       <= rs_d;
      db_q       <= db_d;
      e_q        <= e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counter, index and next registered-output logic.
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    db_d    = db_q;

    case (state_q)
      S_POWERUP: begin
        if (cnt_q == POWERUP_LAST) begin
          cnt_d   = '0;
          phase_d = PH_INIT;
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH: begin
        rs_d    = word[8];
        db_d    = word[7:0];
        cnt_d   = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (phase_q == PH_INIT && idx_q == 4'd3) begin
            phase_d = PH_ROM;
            idx_d   = '0;
            state_d = S_FETCH;
          end else if (phase_q == PH_ROM && idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          phase_d = PH_ROM;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so lcd_e cannot glitch.
    rom_addr_d = (state_d == S_FETCH && phase_d == PH_ROM) ? idx_d : rom_addr_q;
    e_d        = (state_d == S_PULSE);
    busy_d     = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_db   = db_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer using short test timings. A monitor
// records every output per cycle; the expected timeline is rebuilt from the
// write list and the per-write durations, then compared cycle by cycle.
module tb_lcd_sequencer;

  localparam int POWERUP = 10;
  localparam int SETUP   = 2;
  localparam int EPULSE  = 3;
  localparam int CMD     = 5;
  localparam int CLR     = 8;
  localparam int TR_LEN  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   rw_bad = 0;

  logic [8:0] rom_mem [16];

  logic       tr_e    [TR_LEN];
  logic       tr_rs   [TR_LEN];
  logic [7:0] tr_db   [TR_LEN];
  logic [3:0] tr_addr [TR_LEN];
  logic       tr_busy [TR_LEN];
  logic       tr_done [TR_LEN];

  lcd_sequencer_if bus ();

  lcd_sequencer #(
    .POWERUP_CYC  (POWERUP),
    .SETUP_CYC    (SETUP),
    .E_PULSE_CYC  (EPULSE),
    .CMD_WAIT_CYC (CMD),
    .CLR_WAIT_CYC (CLR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Asynchronous content ROM model.
  assign bus.rom_data = rom_mem[bus.rom_addr];

  always #5 clk = ~clk;

  // Edge counter; trace index k holds the outputs seen after edge k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc < TR_LEN) begin
      tr_e[cyc]    <= bus.lcd_e;
      tr_rs[cyc]   <= bus.lcd_rs;
      tr_db[cyc]   <= bus.lcd_db;
      tr_addr[cyc] <= bus.rom_addr;
      tr_busy[cyc] <= bus.busy;
      tr_done[cyc] <= bus.done;
    end
    if (bus.lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_content();
    rom_mem = '{9'h080, 9'h148, 9'h165, 9'h16C, 9'h16C, 9'h16F, 9'h120, 9'h157,
                9'h16F, 9'h172, 9'h16C, 9'h164, 9'h121, 9'h120, 9'h08F, 9'h120};
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  // Outputs must sit at reset values for the whole power-up window.
  task automatic check_powerup(input int r, input string tag);
    int bad = 0;
    for (int k = 1; k <= POWERUP; k++) begin
      if (tr_e[r+k] !== 1'b0 || tr_rs[r+k] !== 1'b0 || tr_db[r+k] !== 8'h00 ||
          tr_addr[r+k] !== 4'd0 || tr_busy[r+k] !== 1'b1 || tr_done[r+k] !== 1'b0)
        bad++;
    end
    check({tag, "_powerup_hold"}, 32'(bad), 32'd0);
  endtask

  // Reference timeline: each write takes 1 + SETUP + EPULSE + wait cycles,
  // with E high for cycles SETUP+1..SETUP+EPULSE of the write and RS/DB
  // fixed from the cycle after FETCH through the next write's FETCH.
  task automatic check_stream(input int t0, input bit with_init, input string tag,
                              output int t_end);
    logic [8:0] w_q [$];
    int         t, len, bad_e, bad_hold, bad_stat, base;
    bit         clr, exp_e;
    w_q = {};
    if (with_init) begin
      w_q.push_back(9'h038);
      w_q.push_back(9'h00E);
      w_q.push_back(9'h001);
      w_q.push_back(9'h006);
    end
    base = with_init ? 4 : 0;
    for (int i = 0; i < 16; i++) w_q.push_back(rom_mem[i]);
    t = t0;
    for (int n = 0; n < w_q.size(); n++) begin
      clr = (w_q[n][8] == 1'b0) && (w_q[n][7:0] == 8'h01 || w_q[n][7:0] == 8'h02);
      len = 1 + SETUP + EPULSE + (clr ? CLR : CMD);
      if (n >= base)
        check($sformatf("%s_addr%0d", tag, n - base), 32'(tr_addr[t]), 32'(n - base));
      check($sformatf("%s_word%0d", tag, n),
            32'({tr_rs[t+1+SETUP], tr_db[t+1+SETUP]}), 32'(w_q[n]));
      bad_e = 0; bad_hold = 0; bad_stat = 0;
      for (int k = 0; k < len; k++) begin
        exp_e = (k >= 1 + SETUP) && (k <= SETUP + EPULSE);
        if (tr_e[t+k] !== exp_e) bad_e++;
        if (tr_busy[t+k] !== 1'b1 || tr_done[t+k] !== 1'b0) bad_stat++;
      end
      for (int k = 1; k <= len; k++)
        if ({tr_rs[t+k], tr_db[t+k]} !== w_q[n]) bad_hold++;
      check($sformatf("%s_estrobe%0d", tag, n), 32'(bad_e), 32'd0);
      check($sformatf("%s_hold%0d", tag, n), 32'(bad_hold), 32'd0);
      check($sformatf("%s_status%0d", tag, n), 32'(bad_stat), 32'd0);
      t += len;
    end
    check({tag, "_done_at_end"}, 32'(tr_done[t]), 32'd1);
    check({tag, "_busy_at_end"}, 32'(tr_busy[t]), 32'd0);
    t_end = t;
  endtask

  initial begin
    int r, s, t_end, n;
    bus.start = 1'b0;
    load_content();

    // Reset and power-up.
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_e",    32'(bus.lcd_e),    32'd0);
    check("rst_rs",   32'(bus.lcd_rs),   32'd0);
    check("rst_rw",   32'(bus.lcd_rw),   32'd0);
    check("rst_db",   32'(bus.lcd_db),   32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_busy", 32'(bus.busy),     32'd1);
    check("rst_done", 32'(bus.done),     32'd0);
    r = cyc;
    rst_n = 1'b1;

    // A start pulse mid-stream must not disturb the timeline.
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(400, "run1");
    check_powerup(r, "run1");
    check_stream(r + POWERUP, 1'b1, "run1", t_end);
    check("run1_done_cycle", 32'(t_end - r), 32'd233);
    check("run1_done_before", 32'(tr_done[t_end-1]), 32'd0);

    // Replays with random ROM contents, some entries being clear/home.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(3) == 0)
          rom_mem[i] = {1'b0, 7'd0, ($urandom_range(1) == 0) ? 1'b1 : 1'b0} + 9'(($urandom_range(1)) << 1) - 9'(($urandom_range(0)));
        else
          rom_mem[i] = 9'($urandom);
      end
      @(negedge clk);
      s = cyc + 1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(400, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_done_pre_start", it), 32'(tr_done[s-1]), 32'd1);
      check($sformatf("rnd%0d_start_latency", it), 32'(tr_busy[s]), 32'd1);
      check_stream(s, 1'b0, $sformatf("rnd%0d", it), t_end);
    end

    // Known-content replay: 16 normal writes, done 1+176 after the start cycle.
    load_content();
    @(negedge clk);
    s = cyc + 1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(400, "replay");
    check_stream(s, 1'b0, "replay", t_end);
    check("replay_len", 32'(t_end - s), 32'd176);

    // Mid-operation reset while E is high on ROM entry 7.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.lcd_e === 1'b1 && bus.rom_addr === 4'd7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_found_entry7", 32'(bus.lcd_e), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_e_async",    32'(bus.lcd_e),    32'd0);
    check("midrst_addr_async", 32'(bus.rom_addr), 32'd0);
    check("midrst_db_async",   32'(bus.lcd_db),   32'd0);
    check("midrst_busy_async", 32'(bus.busy),     32'd1);
    repeat (3) @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    wait_done(400, "midrst");
    check_powerup(r, "midrst");
    check("midrst_first_cmd", 32'(tr_db[r+POWERUP+1+SETUP]), 32'h38);
    check_stream(r + POWERUP, 1'b1, "midrst", t_end);
    check("midrst_done_cycle", 32'(t_end - r), 32'd233);

    check("rw_always_low", 32'(rw_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
